// File: rtl/i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Brief    : I2C target with 7-bit device address, 16-bit register pointer
//            and a single-cycle register bus (write/read strobes).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h0A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DEV     = 4'd1,
        ST_DEV_ACK = 4'd2,
        ST_AHI     = 4'd3,
        ST_AHI_ACK = 4'd4,
        ST_ALO     = 4'd5,
        ST_ALO_ACK = 4'd6,
        ST_WR      = 4'd7,
        ST_WR_ACK  = 4'd8,
        ST_RD      = 4'd9,
        ST_RD_ACK  = 4'd10,
        ST_IGNORE  = 4'd11
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic [SYNC_STAGES:0]   r_warm;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_tx;
    logic [7:0]  r_addr_hi;
    logic        r_rw;
    logic        r_ack;
    logic        r_oe;
    logic        r_re_pend;
    logic        r_re_d;

    logic w_scl;
    logic w_sda;
    logic w_armed;
    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_stop;

    assign sda = r_oe ? 1'b0 : 1'bz;

    // Synchronizers idle high; r_warm blocks edge detection until the
    // pipeline holds real bus samples again after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_warm     <= '0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
            r_warm     <= {r_warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_scl   = r_scl_sync[SYNC_STAGES-1];
    assign w_sda   = r_sda_sync[SYNC_STAGES-1];
    assign w_armed = r_warm[SYNC_STAGES];
    assign w_rise  = w_armed &  w_scl & ~r_scl_d;
    assign w_fall  = w_armed & ~w_scl &  r_scl_d;
    assign w_start = w_armed &  w_scl &  r_scl_d &  r_sda_d & ~w_sda;
    assign w_stop  = w_armed &  w_scl &  r_scl_d & ~r_sda_d &  w_sda;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'd0;
            r_tx      <= 8'd0;
            r_addr_hi <= 8'd0;
            r_rw      <= 1'b0;
            r_ack     <= 1'b0;
            r_oe      <= 1'b0;
            r_re_pend <= 1'b0;
            r_re_d    <= 1'b0;
            reg_addr  <= 16'd0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= r_re_pend;
            r_re_pend <= 1'b0;
            r_re_d    <= reg_re;
            if (r_re_d) begin
                r_tx <= reg_rdata;
            end
            if (reg_we) begin
                reg_addr <= reg_addr + 16'd1;
            end

            if (w_start) begin
                r_state <= ST_DEV;
                r_cnt   <= 4'd0;
                r_oe    <= 1'b0;
                busy    <= 1'b0;
            end else if (w_stop) begin
                r_state <= ST_IDLE;
                r_oe    <= 1'b0;
                busy    <= 1'b0;
            end else if (w_rise) begin
                case (r_state)
                    ST_DEV, ST_AHI, ST_ALO, ST_WR: begin
                        r_shift <= {r_shift[6:0], w_sda};
                        r_cnt   <= r_cnt + 4'd1;
                    end
                    ST_RD: r_cnt <= r_cnt + 4'd1;
                    ST_DEV_ACK: begin
                        if (r_rw) begin
                            reg_re <= 1'b1;
                        end
                    end
                    ST_ALO_ACK: reg_addr <= {r_addr_hi, r_shift};
                    ST_WR_ACK: begin
                        reg_we    <= 1'b1;
                        reg_wdata <= r_shift;
                    end
                    // Controller ACK: advance pointer now, strobe the read next cycle
                    ST_RD_ACK: begin
                        r_ack <= ~w_sda;
                        if (!w_sda) begin
                            reg_addr  <= reg_addr + 16'd1;
                            r_re_pend <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (w_fall) begin
                case (r_state)
                    ST_DEV: begin
                        if (r_cnt == 4'd8) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                r_state <= ST_DEV_ACK;
                                r_oe    <= 1'b1;
                                r_rw    <= r_shift[0];
                                busy    <= 1'b1;
                            end else begin
                                r_state <= ST_IGNORE;
                                r_oe    <= 1'b0;
                            end
                        end
                    end
                    ST_AHI: begin
                        if (r_cnt == 4'd8) begin
                            r_state   <= ST_AHI_ACK;
                            r_oe      <= 1'b1;
                            r_addr_hi <= r_shift;
                        end
                    end
                    ST_ALO: begin
                        if (r_cnt == 4'd8) begin
                            r_state <= ST_ALO_ACK;
                            r_oe    <= 1'b1;
                        end
                    end
                    ST_WR: begin
                        if (r_cnt == 4'd8) begin
                            r_state <= ST_WR_ACK;
                            r_oe    <= 1'b1;
                        end
                    end
                    ST_DEV_ACK: begin
                        r_cnt <= 4'd0;
                        if (r_rw) begin
                            r_state <= ST_RD;
                            r_oe    <= ~r_tx[7];
                        end else begin
                            r_state <= ST_AHI;
                            r_oe    <= 1'b0;
                        end
                    end
                    ST_AHI_ACK: begin
                        r_state <= ST_ALO;
                        r_cnt   <= 4'd0;
                        r_oe    <= 1'b0;
                    end
                    ST_ALO_ACK, ST_WR_ACK: begin
                        r_state <= ST_WR;
                        r_cnt   <= 4'd0;
                        r_oe    <= 1'b0;
                    end
                    // MSB is already on the wire when RD is entered
                    ST_RD: begin
                        if (r_cnt == 4'd8) begin
                            r_state <= ST_RD_ACK;
                            r_oe    <= 1'b0;
                        end else begin
                            r_tx <= {r_tx[6:0], 1'b0};
                            r_oe <= ~r_tx[6];
                        end
                    end
                    ST_RD_ACK: begin
                        r_cnt <= 4'd0;
                        if (r_ack) begin
                            r_state <= ST_RD;
                            r_oe    <= ~r_tx[7];
                        end else begin
                            r_state <= ST_IGNORE;
                            r_oe    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target
// Brief    : Directed bus-level bench for i2c_target with a strobe scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target;

    localparam int Q = 60;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        scl     = 1'b1;
    logic        sda_low = 1'b0;
    wire         sda;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_rdata = 8'd0;
    logic        busy;

    typedef struct {
        logic        is_we;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_strobe = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(
        .DEV_ADDR    (7'h0A),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register file model: read data equals the low address byte.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= reg_addr[7:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reg_we || reg_re) begin
            check("strobe_exclusive", {31'd0, reg_we & reg_re}, 32'd0);
            check("strobe_width", {31'd0, prev_strobe}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {14'd0, reg_we, reg_re, reg_addr}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_kind", {31'd0, reg_we}, {31'd0, mon_e.is_we});
                check("strobe_addr", {16'd0, reg_addr}, {16'd0, mon_e.addr});
                if (mon_e.is_we) check("strobe_wdata", {24'd0, reg_wdata}, {24'd0, mon_e.data});
            end
        end
        prev_strobe = reg_we | reg_re;
    end

    task automatic push(input logic is_we, input logic [15:0] addr, input logic [7:0] data);
        exp_t e;
        e.is_we = is_we;
        e.addr  = addr;
        e.data  = data;
        sb.push_back(e);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; #(Q);
        scl     = 1'b1; #(Q);
        sda_low = 1'b1; #(Q);
        scl     = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; #(Q);
        scl     = 1'b1; #(Q);
        sda_low = 1'b0; #(2*Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_low = ~b; #(Q);
        scl     = 1'b1; #(Q);
        s       = sda; #(Q);
        scl     = 1'b0; #(Q);
    endtask

    task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        check(tag, {31'd0, ~s}, {31'd0, exp_ack});
    endtask

    task automatic recv(input logic nack, input logic [7:0] exp_d, input string tag);
        logic       s;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
        check(tag, {24'd0, d}, {24'd0, exp_d});
    endtask

    initial begin
        logic s;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sda",   {31'd0, sda},       32'd1);
        check("rst_addr",  {16'd0, reg_addr},  32'd0);
        check("rst_wdata", {24'd0, reg_wdata}, 32'd0);
        check("rst_we",    {31'd0, reg_we},    32'd0);
        check("rst_re",    {31'd0, reg_re},    32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Single write
        push(1'b1, 16'h1234, 8'hA5);
        i2c_start();
        send(8'h14, 1'b1, "wr_dev_ack");
        send(8'h12, 1'b1, "wr_ahi_ack");
        send(8'h34, 1'b1, "wr_alo_ack");
        send(8'hA5, 1'b1, "wr_data_ack");
        check("wr_busy", {31'd0, busy}, 32'd1);
        i2c_stop();
        check("wr_addr_inc", {16'd0, reg_addr}, 32'h1235);
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);

        // Random read
        push(1'b0, 16'h1212, 8'h00);
        i2c_start();
        send(8'h14, 1'b1, "rr_dev_ack");
        send(8'h12, 1'b1, "rr_ahi_ack");
        send(8'h12, 1'b1, "rr_alo_ack");
        i2c_start();
        send(8'h15, 1'b1, "rr_dev_rd_ack");
        check("rr_busy", {31'd0, busy}, 32'd1);
        recv(1'b1, 8'h12, "rr_data");
        i2c_stop();

        // Burst write wrapping the pointer
        push(1'b1, 16'hFFFF, 8'h01);
        push(1'b1, 16'h0000, 8'h02);
        i2c_start();
        send(8'h14, 1'b1, "bw_dev_ack");
        send(8'hFF, 1'b1, "bw_ahi_ack");
        send(8'hFF, 1'b1, "bw_alo_ack");
        send(8'h01, 1'b1, "bw_d0_ack");
        send(8'h02, 1'b1, "bw_d1_ack");
        i2c_stop();
        check("bw_addr_wrap", {16'd0, reg_addr}, 32'h0001);

        // Address mismatch
        i2c_start();
        send(8'h16, 1'b0, "mm_dev_nack");
        send(8'h12, 1'b0, "mm_byte_nack");
        check("mm_busy", {31'd0, busy}, 32'd0);
        i2c_stop();

        // Burst read ACK, ACK, NACK from 0x0010
        push(1'b0, 16'h0010, 8'h00);
        push(1'b0, 16'h0011, 8'h00);
        push(1'b0, 16'h0012, 8'h00);
        i2c_start();
        send(8'h14, 1'b1, "br_dev_ack");
        send(8'h00, 1'b1, "br_ahi_ack");
        send(8'h10, 1'b1, "br_alo_ack");
        i2c_start();
        send(8'h15, 1'b1, "br_dev_rd_ack");
        recv(1'b0, 8'h10, "br_d0");
        recv(1'b0, 8'h11, "br_d1");
        recv(1'b1, 8'h12, "br_d2");
        i2c_stop();
        check("br_addr_final", {16'd0, reg_addr}, 32'h0012);

        // Reset in the middle of a data byte
        i2c_start();
        send(8'h14, 1'b1, "rs_dev_ack");
        send(8'h00, 1'b1, "rs_ahi_ack");
        send(8'h20, 1'b1, "rs_alo_ack");
        for (int i = 7; i >= 4; i--) clock_bit(1'b0, s);
        sda_low = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rs_sda_released", {31'd0, sda}, 32'd1);
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_addr", {16'd0, reg_addr}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #(Q);
        for (int i = 3; i >= 0; i--) clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        i2c_stop();

        push(1'b1, 16'h0300, 8'h5A);
        i2c_start();
        send(8'h14, 1'b1, "rs2_dev_ack");
        send(8'h03, 1'b1, "rs2_ahi_ack");
        send(8'h00, 1'b1, "rs2_alo_ack");
        send(8'h5A, 1'b1, "rs2_data_ack");
        i2c_stop();
        check("rs2_addr_inc", {16'd0, reg_addr}, 32'h0301);

        repeat (20) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_target.md
# i2c_target

Synthesizable I2C target (responder) for the codec control path: the far end of `i2c_controller`. It decodes START/STOP, matches a 7-bit device address, takes a 16-bit register address and 8-bit data bytes, and drives a simple single-cycle register bus. It replaces the behavioural `codec_bfm` in system-level simulation and hosts on-FPGA control registers reachable over the same two-wire bus.

## Interface
- `DEV_ADDR`, 7'h0A: 7-bit target address to match.
- `SYNC_STAGES`, 2: synchronizer depth on `scl`/`sda` inputs (≥2).

- `clk`  in  1  system clock, ≥20× SCL frequency.
- `rst`  in  1  reset: one clock; reset is synchronous and active-high.
- `scl`  in  1  I2C clock from controller (target never stretches).
- `sda`  inout  1  open-drain data: driven `1'b0` or `1'bz` only.
- `reg_addr`  out  16  register address, auto-incrementing.
- `reg_wdata`  out  8  write data, valid with `reg_we`.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, sampled exactly 1 cycle after `reg_re`.
- `busy`  out  1  high from matched address ACK until STOP/START.

## Operation
- Inputs pass through `SYNC_STAGES` flops, then one history flop for edge detect. START = `sda` fall while `scl` high; STOP = `sda` rise while `scl` high. Bits sampled on `scl` rising edge; target changes `sda` only on the cycle after an `scl` falling edge is detected.
- States: IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- START (incl. repeated) from any state -> DEV, bit counter 0. STOP from any state -> IDLE, `sda` released.
- DEV: shift 8 bits MSB first. Match `[7:1]==DEV_ADDR` -> DEV_ACK (drive 0 for one SCL period); mismatch -> IGNORE (no ACK, releases `sda`).
- After DEV_ACK: R/W=0 -> AHI; R/W=1 -> pulse `reg_re` on ACK-bit rising edge, load `reg_rdata` next cycle into TX shifter -> RD.
- AHI/ALO: receive high then low address byte, ACK each; `reg_addr` updated at ALO ACK. Then WR.
- WR: receive byte, ACK, pulse `reg_we` with `reg_wdata` on the ACK-bit rising edge of SCL; `reg_addr` increments the cycle after `reg_we`. Further bytes repeat WR.
- RD: drive 8 bits MSB first (release for 1s). RD_ACK: sample controller bit; ACK(0) -> `reg_addr`+1, `reg_re` pulse, reload shifter -> RD; NACK(1) -> IGNORE until STOP/START.
- `reg_addr` is 16-bit, wraps 16'hFFFF -> 16'h0000. Address persists across transactions (read after write uses last pointer; Sr after ALO_ACK gives random read).
- Reset values: `sda`=z, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `busy`=0, state IDLE. Reset mid-transfer releases `sda` that cycle and ignores bus until next START.

## Timing
- Input-to-internal latency: `SYNC_STAGES`+1 clocks.
- `sda` output change: 1 clock after internal SCL fall detect; held through the following SCL high.
- `reg_we`/`reg_re`: exactly one clock wide; never both high; at most one per byte.
- `reg_rdata` sampled 1 clock after `reg_re`, always before next SCL fall at ≥20× ratio.
- START/STOP take priority over bit sampling in the same cycle.

## Test plan
- Write: S,0x14,0x12,0x34,0xA5,P -> 4 ACKs, one `reg_we` with `reg_addr`=0x1234, `reg_wdata`=0xA5; then `reg_addr`=0x1235.
- Random read: S,0x14,0x12,0x12,Sr,0x15, `reg_rdata`=0x12, NACK,P -> `reg_re` once at 0x1212, controller `rdata`=0x12.
- Burst wrap: write at 0xFFFF data 0x01,0x02 -> `reg_we` at 0xFFFF then 0x0000.
- Address mismatch: S,0x16,... -> no ACK (`sda` stays z), no strobes, `busy`=0.
- Burst read ACK,ACK,NACK from 0x0010 -> `reg_re` at 0x0010,0x0011,0x0012; none after NACK.
- `rst` asserted mid-WR bit 4 -> `sda`=z next cycle, no `reg_we`; subsequent full write succeeds.
